// File: rtl/tnoc_input_port_requester_if.sv
// Link-side and port-control signals of one router input port; master = requester, slave = link/arbiters.
// All widths follow the router flit format; the 5-bit vectors are ordered xp, xm, yp, ym, l.
interface tnoc_input_port_requester_if #(
  parameter int FLIT_WIDTH = 40
);
  logic                  flit_in_valid;
  logic                  flit_in_ready;
  logic [FLIT_WIDTH-1:0] flit_in;
  logic [4:0]            port_request;
  logic [4:0]            port_grant;
  logic [4:0]            port_free;
  logic [4:0]            flit_out_valid;
  logic [4:0]            flit_out_ready;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  error;

  modport master (
    input  flit_in_valid, flit_in, port_grant, flit_out_ready,
    output flit_in_ready, port_request, port_free, flit_out_valid, flit_out, error
  );

  modport slave (
    output flit_in_valid, flit_in, port_grant, flit_out_ready,
    input  flit_in_ready, port_request, port_free, flit_out_valid, flit_out, error
  );
endinterface

// File: rtl/tnoc_input_port_requester.sv
// Buffers one link, XY-routes each packet, requests/forwards to one output port; head-to-valid 3 cycles.
// Input stalls only when the FIFO is full (no bypass); TNOC_INPUT_PORT_ORPHAN_CHECK_EN drops stray body flits in IDLE.
module tnoc_input_port_requester #(
  parameter int FLIT_WIDTH = 40,
  parameter int ID_WIDTH   = 3,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                          clk,
  input logic                          rst,
  tnoc_input_port_requester_if.master  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ID_WIDTH-1:0] LX = ID_WIDTH'(LOCAL_X);
  localparam logic [ID_WIDTH-1:0] LY = ID_WIDTH'(LOCAL_Y);

  typedef enum logic [1:0] {IDLE, REQUEST, FORWARD} state_e;

  logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  state_e                state_q;
  logic [4:0]            route_q, req_q;

  logic                  empty, push, pop, fwd_hs, orphan;
  logic [FLIT_WIDTH-1:0] head;
  logic [4:0]            fwd_vld, head_route;

  function automatic logic [4:0] calc_route(input logic [ID_WIDTH-1:0] dx,
                                            input logic [ID_WIDTH-1:0] dy);
    if (dx > LX)      return 5'b00001;
    else if (dx < LX) return 5'b00010;
    else if (dy > LY) return 5'b00100;
    else if (dy < LY) return 5'b01000;
    else              return 5'b10000;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_route = calc_route(head[ID_WIDTH-1:0], head[2*ID_WIDTH-1:ID_WIDTH]);

  assign bus.flit_in_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push              = bus.flit_in_valid & bus.flit_in_ready;

  assign fwd_vld = (state_q == FORWARD) ? (route_q & {5{~empty}}) : 5'b0;
  assign fwd_hs  = |(fwd_vld & bus.flit_out_ready);

`ifdef TNOC_INPUT_PORT_ORPHAN_CHECK_EN
  // A body flit at the head while idle has lost its header: discard it.
  assign orphan    = (state_q == IDLE) & ~empty & ~head[FLIT_WIDTH-1];
  assign bus.error = orphan;
`else
  assign orphan    = 1'b0;
  assign bus.error = 1'b0;
`endif

  assign pop = fwd_hs | orphan;

  assign bus.port_request   = req_q;
  assign bus.flit_out_valid = fwd_vld;
  assign bus.flit_out       = (state_q == FORWARD) ? head : '0;
  assign bus.port_free      = (fwd_hs & head[FLIT_WIDTH-2]) ? route_q : 5'b0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Request is held from route latch until the tail leaves; grant is only consulted in REQUEST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 5'b0;
      req_q   <= 5'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty && !orphan) begin
            route_q <= head_route;
            req_q   <= head_route;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          if (|(bus.port_grant & route_q)) state_q <= FORWARD;
        end
        FORWARD: begin
          if (fwd_hs && head[FLIT_WIDTH-2]) begin
            req_q   <= 5'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tnoc_input_port_requester.sv
// Self-checking bench: packet-level reference model compared every cycle, plus directed literal checks.
module tb_tnoc_input_port_requester;
  localparam int FW    = 40;
  localparam int IDW   = 3;
  localparam int LX    = 1;
  localparam int LY    = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tnoc_input_port_requester_if #(.FLIT_WIDTH(FW)) bus();

  tnoc_input_port_requester #(
    .FLIT_WIDTH(FW), .ID_WIDTH(IDW), .LOCAL_X(LX), .LOCAL_Y(LY), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk_flit(input bit hd, input bit tl, input int dx, input int dy);
    logic [63:0]   r;
    logic [FW-1:0] f;
    r = {$urandom, $urandom};
    f = r[FW-1:0];
    f[FW-1] = hd;
    f[FW-2] = tl;
    f[2:0]  = dx[2:0];
    f[5:3]  = dy[2:0];
    return f;
  endfunction

  // Dimension-order routing straight from the rules: X first, then Y, else local.
  function automatic logic [4:0] route_of(input logic [FW-1:0] f);
    int dx, dy;
    dx = int'(f[2:0]);
    dy = int'(f[5:3]);
    if (dx > LX) return 5'b00001;
    if (dx < LX) return 5'b00010;
    if (dy > LY) return 5'b00100;
    if (dy < LY) return 5'b01000;
    return 5'b10000;
  endfunction

  // Upstream source: presents src_q[0] until accepted.
  logic [FW-1:0] src_q[$];
  int  acc_cnt = 0;
  bit  gaps = 0;
  bit  drv_acc;

  task automatic push_pkt(input int len, input int dx, input int dy);
    for (int i = 0; i < len; i++) src_q.push_back(mk_flit(i == 0, i == len - 1, dx, dy));
  endtask

  initial begin
    bus.flit_in_valid = 1'b0;
    bus.flit_in = '0;
    forever begin
      @(negedge clk);
      drv_acc = bus.flit_in_valid && bus.flit_in_ready && !rst;
      @(posedge clk);
      #1;
      if (drv_acc) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        acc_cnt++;
      end
      if (src_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        bus.flit_in_valid = 1'b1;
        bus.flit_in = src_q[0];
      end else begin
        bus.flit_in_valid = 1'b0;
      end
    end
  end

  // Reference model: buffer contents as a queue plus the packet phase (0 idle, 1 waiting grant, 2 sending).
  logic [FW-1:0] mq[$];
  int            phase = 0;
  logic [4:0]    mroute = 5'b0;
  logic          e_rdy, m_hs, m_tail, m_orph, m_push;
  logic [4:0]    e_req, e_fv, e_free;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      phase  = 0;
      mroute = 5'b0;
    end else begin
      e_rdy  = (mq.size() != DEPTH);
      e_req  = (phase != 0) ? mroute : 5'b0;
      e_fv   = (phase == 2 && mq.size() > 0) ? mroute : 5'b0;
      m_hs   = |(e_fv & bus.flit_out_ready);
      m_tail = m_hs && mq[0][FW-2];
      e_free = m_tail ? mroute : 5'b0;
`ifdef TNOC_INPUT_PORT_ORPHAN_CHECK_EN
      m_orph = (phase == 0) && (mq.size() > 0) && !mq[0][FW-1];
`else
      m_orph = 1'b0;
`endif
      chk("m_in_ready", bus.flit_in_ready, e_rdy);
      chk("m_request", bus.port_request, e_req);
      chk("m_out_valid", bus.flit_out_valid, e_fv);
      chk("m_free", bus.port_free, e_free);
      chk("m_error", bus.error, m_orph);
      if (e_fv != 5'b0) chk("m_flit_out", bus.flit_out, mq[0]);

      m_push = bus.flit_in_valid && e_rdy;
      case (phase)
        0: if (mq.size() > 0 && !m_orph) begin
             mroute = route_of(mq[0]);
             phase  = 1;
           end
        1: if (|(bus.port_grant & mroute)) phase = 2;
        default: if (m_tail) phase = 0;
      endcase
      if (m_hs || m_orph) void'(mq.pop_front());
      if (m_push) mq.push_back(bus.flit_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    bus.port_grant = 5'b0;
    bus.flit_out_ready = 5'b0;
    tick();
    tick();
    rst = 1'b0;
    acc_cnt = 0;
  endtask

  logic [FW-1:0] p [6];
  bit            drained;

  initial begin
    bus.port_grant = 5'b0;
    bus.flit_out_ready = 5'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_request", bus.port_request, 5'b0);
    chk("rst_out_valid", bus.flit_out_valid, 5'b0);
    chk("rst_free", bus.port_free, 5'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_flit_out", bus.flit_out, 40'h0);
    chk("rst_in_ready", bus.flit_in_ready, 1'b1);

    // Single flit to (3,1): xp, request cycle 2, valid+free cycle 3
    tick();
    bus.flit_out_ready = 5'h1f;
    p[0] = mk_flit(1, 1, 3, 1);
    src_q.push_back(p[0]);
    tick();                       // cycle 0
    tick();                       // cycle 1
    @(negedge clk);
    chk("t1_req_c1", bus.port_request, 5'b0);
    tick();                       // cycle 2
    bus.port_grant = 5'b00001;
    @(negedge clk);
    chk("t1_req_c2", bus.port_request, 5'b00001);
    chk("t1_vld_c2", bus.flit_out_valid, 5'b0);
    tick();                       // cycle 3
    bus.port_grant = 5'b0;
    @(negedge clk);
    chk("t1_vld_c3", bus.flit_out_valid, 5'b00001);
    chk("t1_free_c3", bus.port_free, 5'b00001);
    chk("t1_flit_c3", bus.flit_out, p[0]);
    tick();                       // cycle 4
    @(negedge clk);
    chk("t1_req_c4", bus.port_request, 5'b0);
    chk("t1_free_c4", bus.port_free, 5'b0);

    // 4-flit packet to (1,0): ym, grant after 5 cycles, dropped again during forwarding
    do_reset();
    bus.flit_out_ready = 5'h1f;
    for (int i = 0; i < 4; i++) begin
      p[i] = mk_flit(i == 0, i == 3, 1, 0);
      src_q.push_back(p[i]);
    end
    tick();
    tick();
    tick();                       // cycle 2
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_req_wait", bus.port_request, 5'b01000);
      chk("t2_vld_wait", bus.flit_out_valid, 5'b0);
      tick();
    end
    bus.port_grant = 5'b01000;
    tick();
    bus.port_grant = 5'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_vld", bus.flit_out_valid, 5'b01000);
      chk("t2_flit", bus.flit_out, p[i]);
      chk("t2_free", bus.port_free, (i == 3) ? 5'b01000 : 5'b0);
      tick();
    end
    @(negedge clk);
    chk("t2_req_end", bus.port_request, 5'b0);

    // Local destination; wrong-bit grant must not start forwarding
    do_reset();
    bus.flit_out_ready = 5'h1f;
    p[0] = mk_flit(1, 1, 1, 1);
    src_q.push_back(p[0]);
    tick();
    tick();
    tick();                       // cycle 2
    bus.port_grant = 5'b00001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_req", bus.port_request, 5'b10000);
      chk("t4_no_vld", bus.flit_out_valid, 5'b0);
      tick();
    end
    bus.port_grant = 5'b10000;
    tick();
    bus.port_grant = 5'b0;
    @(negedge clk);
    chk("t4_vld", bus.flit_out_valid, 5'b10000);
    chk("t4_free", bus.port_free, 5'b10000);

    // FIFO fill: 6 flits offered, output stalled
    do_reset();
    bus.port_grant = 5'b00001;
    push_pkt(6, 3, 1);
    repeat (12) tick();
    @(negedge clk);
    chk("t3_accepted4", acc_cnt, 4);
    chk("t3_full", bus.flit_in_ready, 1'b0);
    chk("t3_stalled_vld", bus.flit_out_valid, 5'b00001);
    tick();
    bus.flit_out_ready = 5'h1f;
    @(negedge clk);
    chk("t3_no_bypass", bus.flit_in_ready, 1'b0);
    tick();
    bus.flit_out_ready = 5'b0;
    @(negedge clk);
    chk("t3_ready_back", bus.flit_in_ready, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t3_accepted5", acc_cnt, 5);
    chk("t3_full_again", bus.flit_in_ready, 1'b0);
    tick();
    bus.flit_out_ready = 5'h1f;
    repeat (12) tick();
    @(negedge clk);
    chk("t3_accepted6", acc_cnt, 6);
    chk("t3_req_done", bus.port_request, 5'b0);

    // Reset after 2 of 4 flits forwarded
    do_reset();
    bus.port_grant = 5'b00001;
    push_pkt(4, 3, 1);
    repeat (6) tick();
    bus.flit_out_ready = 5'h1f;
    tick();
    tick();
    bus.flit_out_ready = 5'b0;
    rst = 1'b1;
    src_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_req", bus.port_request, 5'b0);
    chk("t5_vld", bus.flit_out_valid, 5'b0);
    chk("t5_free", bus.port_free, 5'b0);
    chk("t5_flit", bus.flit_out, 40'h0);
    chk("t5_in_ready", bus.flit_in_ready, 1'b1);
    tick();
    @(negedge clk);
    chk("t5_free_after", bus.port_free, 5'b0);
    chk("t5_req_after", bus.port_request, 5'b0);

    // Body flit arriving while idle
    do_reset();
    bus.flit_out_ready = 5'h1f;
    src_q.push_back(mk_flit(0, 1, 3, 1));
    tick();
    tick();                       // cycle 1
`ifdef TNOC_INPUT_PORT_ORPHAN_CHECK_EN
    @(negedge clk);
    chk("t6_error", bus.error, 1'b1);
    tick();
    @(negedge clk);
    chk("t6_error_pulse", bus.error, 1'b0);
    chk("t6_req", bus.port_request, 5'b0);
    tick();
    @(negedge clk);
    chk("t6_req_later", bus.port_request, 5'b0);
`else
    @(negedge clk);
    chk("t6_error", bus.error, 1'b0);
    tick();                       // cycle 2
    bus.port_grant = 5'b00001;
    @(negedge clk);
    chk("t6_req", bus.port_request, 5'b00001);
    tick();
    bus.port_grant = 5'b0;
    @(negedge clk);
    chk("t6_vld", bus.flit_out_valid, 5'b00001);
    chk("t6_free", bus.port_free, 5'b00001);
`endif

    // Random traffic against the model
    do_reset();
    gaps = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.port_grant = 5'($urandom_range(0, 31));
      bus.flit_out_ready = 5'($urandom_range(0, 31));
      if (src_q.size() < 4)
        push_pkt($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    gaps = 0;
    bus.port_grant = 5'h1f;
    bus.flit_out_ready = 5'h1f;
    drained = 0;
    for (int c = 0; c < 300 && !drained; c++) begin
      tick();
      drained = (src_q.size() == 0) && (mq.size() == 0) && (phase == 0);
    end
    chk("rand_drain", drained, 1'b1);
    @(negedge clk);
    chk("rand_req_idle", bus.port_request, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tnoc_input_port_requester.md
Name: tnoc_input_port_requester

Overview:
- Input-side counterpart of a router output block: receives flits from one link, buffers them, and routes each packet by XY dimension order.
- Requests the chosen output port through the port-control handshake (request/grant/free), then forwards the packet's flits to that port's flit input.
- One instance per router input port (xp, xm, yp, ym, l).

Parameters:
- FLIT_WIDTH, 40: flit width. Bit [FLIT_WIDTH-1] = head, bit [FLIT_WIDTH-2] = tail. In a head flit, bits [2*ID_WIDTH-1:ID_WIDTH] = dest_y and bits [ID_WIDTH-1:0] = dest_x.
- ID_WIDTH, 3: width of each coordinate.
- LOCAL_X, 0: this router's X id.
- LOCAL_Y, 0: this router's Y id.
- FIFO_DEPTH, 4: input buffer depth, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flit_in_valid  in  1  upstream flit valid
- flit_in_ready  out  1  buffer can accept
- flit_in  in  FLIT_WIDTH  upstream flit
- port_request  out  5  one-hot output-port request; bit order xp,xm,yp,ym,l
- port_grant  in  5  grant from the output-port arbitrators, same order
- port_free  out  5  one-cycle release pulse at end of packet
- flit_out_valid  out  5  per-port valid; only the granted bit may be set
- flit_out_ready  in  5  per-port ready
- flit_out  out  FLIT_WIDTH  flit, shared by all 5 ports
- error  out  1  orphan-flit pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values:
  - All outputs 0.
  - flit_in_ready = 1 in the first cycle after reset is released.
  - FIFO empty; FSM in IDLE; route register 0.
- FIFO:
  - Registered, with count 0..FIFO_DEPTH.
  - flit_in_ready = (count != FIFO_DEPTH). There is no bypass, so ready stays 0 when full even if a pop happens in the same cycle.
  - Push on flit_in_valid & flit_in_ready; pop on the forwarding handshake.
  - Simultaneous push and pop leaves count unchanged.
  - A flit written at edge N is at the FIFO head from cycle N+1. Pointers wrap modulo FIFO_DEPTH.
- Routing (from the head flit's fields, unsigned compares):
  - dest_x > LOCAL_X -> xp (bit0)
  - dest_x < LOCAL_X -> xm (bit1)
  - else dest_y > LOCAL_Y -> yp (bit2)
  - else dest_y < LOCAL_Y -> ym (bit3)
  - else -> l (bit4)
- FSM states:
  - IDLE: if the FIFO is non-empty, latch the one-hot route from the head flit and go to REQUEST.
  - REQUEST: port_request = route. If (port_grant & route) != 0, go to FORWARD next cycle. Grant bits outside route are ignored.
  - FORWARD:
    - port_request = route; flit_out = FIFO head; flit_out_valid = route & {5{!empty}}.
    - Handshake = |(flit_out_valid & flit_out_ready); the head is popped on the handshake.
    - If the popped flit has tail=1: port_free = route for that cycle, port_request drops the next cycle, next state IDLE.
    - FIFO empty mid-packet: valid deasserts and the FSM stays in FORWARD.
- Single-flit packet (head=1, tail=1): REQUEST -> FORWARD -> IDLE; free pulses with the single handshake.
- Latency: head written at edge 0 -> route latched at edge 1 -> request high in cycle 2 -> grant sampled in cycle 2 -> flit_out_valid high in cycle 3. Body flits then move 1 per cycle while ready=1.
- Back-to-back packets: IDLE is entered for at least 1 cycle between packets.
- Grant deasserted while in FORWARD: ignored; the packet completes.
- Reset mid-packet: everything returns to reset values the next cycle. No free pulse is issued.

Optional Feature:
- Macro: TNOC_INPUT_PORT_ORPHAN_CHECK_EN.
- Enabled: in IDLE, a FIFO head with head=0 is popped without forwarding, error pulses high for 1 cycle, and the FSM stays in IDLE.
- Disabled: the head bit is not checked in IDLE; the flit is routed as if it were a head. The error port is tied 0.

Test Plan:
- LOCAL=(1,1); single flit head=tail=1 with dest (3,1), written cycle 0 -> port_request=5'b00001 in cycle 2; grant=5'b00001 in cycle 2 -> flit_out_valid=5'b00001 in cycle 3; with ready=1, port_free=5'b00001 in cycle 3 and request=0 in cycle 4.
- 4-flit packet with dest (1,0), grant delayed 5 cycles -> request=5'b01000 held throughout; flits emerge in order on consecutive cycles; port_free pulses only with the tail.
- FIFO_DEPTH=4, output ready=0, 6 flits offered -> flit_in_ready=0 after 4 accepted. Releasing ready pops one; ready returns the next cycle and no flit is lost.
- Dest equal to local (1,1) -> route l (5'b10000). Assert wrong-bit grant 5'b00001 -> no forwarding until bit4 is granted.
- Reset asserted mid-packet after 2 of 4 flits -> next cycle all outputs 0, flit_in_ready=1, no port_free.
- Macro defined: body flit (head=0) arrives in IDLE -> error pulses 1 cycle, flit dropped, request stays 0. Macro undefined: the same flit is requested and forwarded.
